// File: rtl/mul_unit_if.sv
// Issue-side and writeback-side signals of the multiply unit, bundled so the
// unit (slave) and its neighbours or a bench (master) share one port list.
interface mul_unit_if;
    logic        iss_mul_oper;
    logic [31:0] iss_ex_rega;
    logic [31:0] iss_ex_regb;
    logic [2:0]  iss_ex_funct3;
    logic [4:0]  iss_ex_regdest;
    logic        iss_ex_writereg;
    logic        wb_mul_ready;

    logic        mul_wb_valid;
    logic [31:0] mul_wb_data;
    logic [4:0]  mul_wb_regdest;
    logic        mul_wb_writereg;
    logic        mul_stall;
    logic        mul_sb_release;
    logic [4:0]  mul_sb_addr;
    logic        mul_busy;

    modport slave (
        input  iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_funct3,
               iss_ex_regdest, iss_ex_writereg, wb_mul_ready,
        output mul_wb_valid, mul_wb_data, mul_wb_regdest, mul_wb_writereg,
               mul_stall, mul_sb_release, mul_sb_addr, mul_busy
    );

    modport master (
        output iss_mul_oper, iss_ex_rega, iss_ex_regb, iss_ex_funct3,
               iss_ex_regdest, iss_ex_writereg, wb_mul_ready,
        input  mul_wb_valid, mul_wb_data, mul_wb_regdest, mul_wb_writereg,
               mul_stall, mul_sb_release, mul_sb_addr, mul_busy
    );
endinterface

// File: rtl/mul_unit.sv
// Fixed-latency RV32M multiply unit: the result is formed as an op enters slot 0
// and then travels STAGES slots to the tail, which drives writeback directly.
module mul_unit #(
    parameter int STAGES = 4
) (
    input  logic      clock,
    input  logic      reset,
    mul_unit_if.slave bus
);
    localparam int TAIL = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] writereg_q, writereg_d;
    logic [31:0]       data_q     [STAGES];
    logic [31:0]       data_d     [STAGES];
    logic [4:0]        regdest_q  [STAGES];
    logic [4:0]        regdest_d  [STAGES];

    logic        stall;
    logic        retire;
    logic        rs1_signed;
    logic        rs2_signed;
    logic [63:0] a_wide;
    logic [63:0] b_wide;
    logic [63:0] product;
    logic [31:0] result;

    // Extending straight to 64 bits gives the same low 64 product bits as a
    // 33-bit signed extension followed by a 66-bit multiply.
    always_comb begin
        rs1_signed = (bus.iss_ex_funct3[1:0] != 2'b11);
        rs2_signed = (bus.iss_ex_funct3[1:0] == 2'b00) || (bus.iss_ex_funct3[1:0] == 2'b01);
        a_wide     = {{32{rs1_signed & bus.iss_ex_rega[31]}}, bus.iss_ex_rega};
        b_wide     = {{32{rs2_signed & bus.iss_ex_regb[31]}}, bus.iss_ex_regb};
        product    = a_wide * b_wide;
        result     = '0;
        if (!bus.iss_ex_funct3[2]) begin
            result = (bus.iss_ex_funct3[1:0] == 2'b00) ? product[31:0] : product[63:32];
        end
    end

    assign stall  = valid_q[TAIL] & ~bus.wb_mul_ready;
    assign retire = valid_q[TAIL] & bus.wb_mul_ready;

    // Whole pipe advances together; a stall freezes every slot and drops the issue.
    always_comb begin
        valid_d    = valid_q;
        writereg_d = writereg_q;
        data_d     = data_q;
        regdest_d  = regdest_q;
        if (!stall) begin
            for (int i = TAIL; i > 0; i--) begin
                valid_d[i]    = valid_q[i-1];
                writereg_d[i] = writereg_q[i-1];
                data_d[i]     = data_q[i-1];
                regdest_d[i]  = regdest_q[i-1];
            end
            valid_d[0]    = bus.iss_mul_oper;
            data_d[0]     = bus.iss_mul_oper ? result : 32'h0;
            regdest_d[0]  = bus.iss_mul_oper ? bus.iss_ex_regdest : 5'd0;
            writereg_d[0] = bus.iss_mul_oper & bus.iss_ex_writereg & (bus.iss_ex_regdest != 5'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            writereg_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i]    <= '0;
                regdest_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            writereg_q <= writereg_d;
            data_q     <= data_d;
            regdest_q  <= regdest_d;
        end
    end

    // writereg is already cleared for x0 at entry, so it alone qualifies the release.
    assign bus.mul_wb_valid    = valid_q[TAIL];
    assign bus.mul_wb_data     = valid_q[TAIL] ? data_q[TAIL] : 32'h0;
    assign bus.mul_wb_regdest  = valid_q[TAIL] ? regdest_q[TAIL] : 5'd0;
    assign bus.mul_wb_writereg = valid_q[TAIL] & writereg_q[TAIL];
    assign bus.mul_stall       = stall;
    assign bus.mul_sb_release  = retire & writereg_q[TAIL];
    assign bus.mul_sb_addr     = retire ? regdest_q[TAIL] : 5'd0;
    assign bus.mul_busy        = |valid_q;
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, backpressure and
// reset sequences, then random traffic against a queue-based latency model.
module tb_mul_unit;
    localparam int STAGES = 4;

    logic clock = 1'b0;
    logic reset;

    mul_unit_if bus ();

    mul_unit #(.STAGES(STAGES)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  regdest;
        logic        writereg;
        int          age;
    } flight_t;

    typedef struct {
        logic [31:0] rega;
        logic [31:0] regb;
        logic [2:0]  funct3;
        logic [4:0]  regdest;
        logic        writereg;
        logic [31:0] exp_data;
        logic        exp_writereg;
        logic        exp_release;
    } vec_t;

    flight_t mq[$];
    vec_t    vecs[9];
    int      checks = 0;
    int      errors = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic, independent of how the unit extends operands.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] f);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'h0, a};
        longint unsigned ub = {32'h0, b};
        logic [63:0]     p;
        case (f)
            3'b000:  begin p = ua * ub; return p[31:0];  end
            3'b001:  begin p = sa * sb; return p[63:32]; end
            3'b010:  begin p = sa * ub; return p[63:32]; end
            3'b011:  begin p = ua * ub; return p[63:32]; end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic tail_valid();
        return (mq.size() > 0) && (mq[0].age == STAGES - 1);
    endfunction

    task automatic checkOutput();
        logic        tv;
        logic        rdy;
        logic [31:0] t_data;
        logic [4:0]  t_rd;
        logic        t_wr;
        tv     = tail_valid();
        rdy    = bus.wb_mul_ready;
        t_data = tv ? mq[0].data : 32'h0;
        t_rd   = tv ? mq[0].regdest : 5'd0;
        t_wr   = tv && mq[0].writereg && (mq[0].regdest != 5'd0);
        check_eq("wb_valid",    32'(bus.mul_wb_valid),    32'(tv));
        check_eq("wb_data",     bus.mul_wb_data,          t_data);
        check_eq("wb_regdest",  32'(bus.mul_wb_regdest),  32'(t_rd));
        check_eq("wb_writereg", 32'(bus.mul_wb_writereg), 32'(t_wr));
        check_eq("stall",       32'(bus.mul_stall),       32'(tv && !rdy));
        check_eq("sb_release",  32'(bus.mul_sb_release),  32'(t_wr && rdy));
        check_eq("sb_addr",     32'(bus.mul_sb_addr),     32'((tv && rdy) ? t_rd : 5'd0));
        check_eq("busy",        32'(bus.mul_busy),        32'(mq.size() > 0));
    endtask

    task automatic applyStimulus(input logic rst, input logic oper, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] f, input logic [4:0] rd,
                                 input logic wr, input logic rdy);
        reset               = rst;
        bus.iss_mul_oper    = oper;
        bus.iss_ex_rega     = a;
        bus.iss_ex_regb     = b;
        bus.iss_ex_funct3   = f;
        bus.iss_ex_regdest  = rd;
        bus.iss_ex_writereg = wr;
        bus.wb_mul_ready    = rdy;
        @(negedge clock);
        checkOutput();
    endtask

    task automatic tick();
        logic    stall;
        logic    tv;
        flight_t n;
        tv        = tail_valid();
        stall     = tv && !bus.wb_mul_ready;
        n.data    = ref_result(bus.iss_ex_rega, bus.iss_ex_regb, bus.iss_ex_funct3);
        n.regdest = bus.iss_ex_regdest;
        n.writereg = bus.iss_ex_writereg;
        n.age     = 0;
        @(posedge clock);
        if (reset) begin
            mq.delete();
        end else if (!stall) begin
            if (tv) void'(mq.pop_front());
            foreach (mq[i]) mq[i].age = mq[i].age + 1;
            if (bus.iss_mul_oper) mq.push_back(n);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, rdy);
        tick();
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          stall_seen;
        int          got;
        int          held;
        int          leaked;
        logic [31:0] seen[3];
        int          seen_cyc[3];

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0002, 3'b000, 5'd5,  1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0002, 3'b011, 5'd5,  1'b1, 32'h0000_0001, 1'b1, 1'b1};
        vecs[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b001, 5'd6,  1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b010, 5'd6,  1'b1, 32'h8000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 3'b000, 5'd6,  1'b1, 32'h8000_0000, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0003, 32'h0000_0007, 3'b000, 5'd0,  1'b1, 32'h0000_0015, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0005, 32'h0000_0006, 3'b100, 5'd7,  1'b1, 32'h0000_0000, 1'b1, 1'b1};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 5'd31, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1};
        vecs[8] = '{32'h0000_000A, 32'h0000_000A, 3'b000, 5'd9,  1'b0, 32'h0000_0064, 1'b0, 1'b0};

        reset               = 1'b1;
        bus.iss_mul_oper    = 1'b1;
        bus.iss_ex_rega     = 32'h1234;
        bus.iss_ex_regb     = 32'h5678;
        bus.iss_ex_funct3   = 3'b000;
        bus.iss_ex_regdest  = 5'd3;
        bus.iss_ex_writereg = 1'b1;
        bus.wb_mul_ready    = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b1, 32'h1234, 32'h5678, 3'b000, 5'd3, 1'b1, 1'b1);
        tick();
        repeat (10) idle(1'b1);

        for (int v = 0; v < 9; v++) begin
            applyStimulus(1'b0, 1'b1, vecs[v].rega, vecs[v].regb, vecs[v].funct3,
                          vecs[v].regdest, vecs[v].writereg, 1'b1);
            tick();
            repeat (STAGES - 1) idle(1'b1);
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
            check_eq($sformatf("vec%0d_valid", v),    32'(bus.mul_wb_valid),    32'h1);
            check_eq($sformatf("vec%0d_data", v),     bus.mul_wb_data,          vecs[v].exp_data);
            check_eq($sformatf("vec%0d_writereg", v), 32'(bus.mul_wb_writereg), 32'(vecs[v].exp_writereg));
            check_eq($sformatf("vec%0d_release", v),  32'(bus.mul_sb_release),  32'(vecs[v].exp_release));
            check_eq($sformatf("vec%0d_addr", v),     32'(bus.mul_sb_addr),     32'(vecs[v].regdest));
            tick();
        end

        // Three back-to-back ops, tail held off for three cycles while junk is offered.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 32'(i + 2), 32'(i + 3), 3'b000, 5'(10 + i), 1'b1, 1'b1);
            tick();
        end
        stall_seen = 0;
        got        = 0;
        held       = 0;
        for (int c = 0; c < 20; c++) begin
            if (tail_valid() && held < 3) begin
                applyStimulus(1'b0, 1'b1, 32'hDEAD, 32'h3, 3'b000, 5'd20, 1'b1, 1'b0);
                held++;
            end else begin
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
            end
            if (bus.mul_stall === 1'b1) stall_seen++;
            if (bus.mul_wb_valid === 1'b1 && bus.wb_mul_ready === 1'b1 && got < 3) begin
                seen[got]     = bus.mul_wb_data;
                seen_cyc[got] = c;
                got++;
            end
            tick();
        end
        check_eq("bp_stall_cycles", 32'(stall_seen), 32'd3);
        check_eq("bp_results", 32'(got), 32'd3);
        if (got == 3) begin
            check_eq("bp_first",  seen[0], 32'd6);
            check_eq("bp_second", seen[1], 32'd12);
            check_eq("bp_third",  seen[2], 32'd20);
            check_eq("bp_gap01", 32'(seen_cyc[1] - seen_cyc[0]), 32'd1);
            check_eq("bp_gap12", 32'(seen_cyc[2] - seen_cyc[1]), 32'd1);
        end

        // Two ops in flight, then reset: neither may ever reach writeback.
        applyStimulus(1'b0, 1'b1, 32'd7, 32'd8, 3'b000, 5'd12, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 32'd9, 32'd9, 3'b001, 5'd13, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
        check_eq("midreset_busy", 32'(bus.mul_busy), 32'h0);
        tick();
        leaked = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
            if (bus.mul_wb_valid !== 1'b0 || bus.mul_sb_release !== 1'b0) leaked++;
            tick();
        end
        check_eq("midreset_leak", 32'(leaked), 32'd0);

        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
                          3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            tick();
        end
        repeat (STAGES + 2) idle(1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b1);
        check_eq("drain_busy", 32'(bus.mul_busy), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Pipelined integer multiply functional unit sitting directly downstream of the issue stage.
- Consumes operations flagged by iss_mul_oper, using operand values and destination info latched by issue.
- Computes RV32M MUL/MULH/MULHSU/MULHU over a fixed-latency pipeline and presents results to the writeback arbiter with a valid/ready handshake.
- Reports completed destinations so the scoreboard can release the pending entry.

Parameters:
STAGES, 4, pipeline depth = issue-to-result latency in cycles (legal 2..8)

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
iss_mul_oper  in  1  issue presents a multiply op this cycle
iss_ex_rega  in  32  operand rs1 value
iss_ex_regb  in  32  operand rs2 value
iss_ex_funct3  in  3  RV32M funct3 selecting the variant
iss_ex_regdest  in  5  destination register
iss_ex_writereg  in  1  op writes the register file
wb_mul_ready  in  1  writeback arbiter accepts the result this cycle
mul_wb_valid  out  1  result valid at pipeline tail
mul_wb_data  out  32  result value
mul_wb_regdest  out  5  destination of the tail op
mul_wb_writereg  out  1  tail op writes the register file
mul_stall  out  1  pipeline frozen; issue must not assert iss_mul_oper
mul_sb_release  out  1  scoreboard clear strobe (one cycle per retired write)
mul_sb_addr  out  5  register whose pending bit is cleared
mul_busy  out  1  any pipeline slot holds a valid op

Behaviour:
- Reset (synchronous, active-high): clears all slot valid bits, data, regdest and writereg.
  - Outputs after the reset edge: mul_wb_valid=0, mul_wb_data=0, mul_wb_regdest=0, mul_wb_writereg=0, mul_sb_release=0, mul_sb_addr=0, mul_busy=0, mul_stall=0.
  - Reset mid-operation discards all in-flight ops without any release strobe.
- Pipeline: STAGES slots, slot 0 at the head. Each slot holds valid, 32-bit partial/final result, regdest, writereg.
  - The tail slot (STAGES-1) drives the mul_wb_* outputs directly.
  - Output fields are 0 whenever tail valid=0.
- Advance:
  - mul_stall = tail valid && !wb_mul_ready (combinational).
  - When mul_stall=0, every slot shifts one position toward the tail on the clock edge.
  - Slot 0 loads {iss_mul_oper, computed data, regdest, writereg}.
  - When mul_stall=1, all slots hold and iss_mul_oper is ignored; the issue stage must hold its op.
- Latency: an op accepted at edge N shows mul_wb_valid=1 after edge N+STAGES-1, i.e. STAGES cycles including the accept cycle, with no stall. Throughput is 1 op/cycle.
- Arithmetic: both operands are extended to 33 bits and a 66-bit signed product is formed. Only the low 64 bits are used.
  - funct3 000 MUL: low 32 bits, operands signedness irrelevant.
  - funct3 001 MULH: high 32, signed x signed.
  - funct3 010 MULHSU: high 32, signed rs1 x unsigned rs2.
  - funct3 011 MULHU: high 32, unsigned x unsigned.
  - funct3 1xx (divide, not handled here): result 32'h0; writereg and regdest still carried so the scoreboard entry retires.
- Product implementation is free (single multiplier registered across stages, or split partial products), but results must be bit-exact at the tail.
- Destination x0: mul_wb_writereg is forced to 0 when regdest=0. No release is generated for x0.
- Retire: a tail op retires on a cycle with mul_wb_valid && wb_mul_ready.
  - On that same cycle, combinationally: mul_sb_release = writereg && regdest!=0, and mul_sb_addr = regdest; otherwise both are 0.
- Simultaneous retire and accept in the same cycle is allowed: the tail leaves, all slots shift, the new op enters slot 0.
- mul_busy = OR of all slot valid bits (combinational).

Test Plan:
- Reset then idle: drive reset=1 for 2 cycles with iss_mul_oper=1 -> all outputs 0, mul_busy=0; after release, 10 idle cycles keep mul_wb_valid=0.
- MUL/MULHU: rega=32'hFFFF_FFFF, regb=32'h0000_0002, funct3=000, regdest=5, wb_mul_ready=1 -> STAGES cycles later mul_wb_data=32'hFFFF_FFFE, regdest=5, mul_sb_release=1 with mul_sb_addr=5. Repeat with funct3=011 -> 32'h0000_0001.
- Signed variants: rega=32'h8000_0000, regb=32'hFFFF_FFFF. MULH -> 32'h0000_0000 (product +2^31). MULHSU -> 32'h8000_0000. MUL -> 32'h8000_0000.
- Back-to-back with backpressure: issue 3 ops on consecutive cycles (results 6, 12, 20 from 2x3, 3x4, 4x5) and hold wb_mul_ready=0 when the first reaches the tail for 3 cycles. Required: mul_stall=1 for exactly those 3 cycles, iss_mul_oper during the stall is ignored, then results emerge in order 6, 12, 20 on consecutive cycles.
- x0 and divide: MUL to regdest=0 -> mul_wb_valid=1, mul_wb_writereg=0, mul_sb_release=0. funct3=100 to regdest=7 -> data 0, release strobe with addr 7.
- Reset mid-flight: issue 2 ops, assert reset one cycle later -> no mul_wb_valid and no mul_sb_release ever appear for those ops; mul_busy=0 after the reset edge.
